// File: rtl/memtest_pkg.sv
// Shared types and constants for the bus memory-test initiator and its LFSR.
package memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_FIN
   } state_t;

   localparam logic [31:0] LFSR_POLY_DEF = 32'h80200003;
   localparam logic [31:0] SEED_ZERO_SUB = 32'h1;

   // Right-shifting Galois step: the shifted-out bit folds the taps back in.
   function automatic logic [31:0] lfsr_next(input logic [31:0] val, input logic [31:0] poly);
      lfsr_next = (val >> 1) ^ (val[0] ? poly : 32'h0);
   endfunction

endpackage

// File: rtl/memtest_lfsr.sv
// 32-bit Galois LFSR pattern source; a zero seed is replaced so the register never locks up.
module memtest_lfsr
   import memtest_pkg::*;
#(
   parameter logic [31:0] POLY = LFSR_POLY_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] seed_bi,
   input  logic        step_i,
   output logic [31:0] val_bo
);

   logic [31:0] val_d;
   logic [31:0] val_q;

   always_comb begin
      val_d = val_q;
      if (load_i) begin
         val_d = (seed_bi == 32'h0) ? SEED_ZERO_SUB : seed_bi;
      end else if (step_i) begin
         val_d = lfsr_next(val_q, POLY);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         val_q <= 32'h0;
      end else begin
         val_q <= val_d;
      end
   end

   assign val_bo = val_q;

endmodule

// File: rtl/bus_memtest_init.sv
// Bus initiator: writes an LFSR pattern over a word range, reads it back and reports the result.
// Build option MEMTEST_TIMEOUT_EN bounds each read-response wait and counts a timeout as an error.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start_i, result registers hold the last outcome
// ST_WR      | write request for word idx held until ack
// ST_RD_REQ  | read request for word idx held until ack
// ST_RD_WAIT | request dropped, waiting for resp (or timeout) to compare
// ST_FIN     | done_o pulse with pass_o valid, back to idle next cycle
module bus_memtest_init
   import memtest_pkg::*;
#(
   parameter int          WSIZE_MAX      = 1024,
   parameter logic [31:0] LFSR_POLY      = LFSR_POLY_DEF,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_bi,
   input  logic [15:0] wsize_bi,
   input  logic [31:0] seed_bi,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_cnt_bo,
   output logic [31:0] first_err_addr_bo,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_bo,
   output logic [31:0] bus_wdata_bo,
   output logic [3:0]  bus_be_bo,
   input  logic        bus_ack_i,
   input  logic        bus_resp_i,
   input  logic [31:0] bus_rdata_bi
);

   state_t      state_d, state_q;
   logic [15:0] idx_d, idx_q;
   logic [15:0] size_d, size_q;
   logic [31:0] base_d, base_q;
   logic [31:0] seed_d, seed_q;
   logic [31:0] addr_d, addr_q;
   logic        req_d, req_q;
   logic        we_d, we_q;
   logic        busy_d, busy_q;
   logic        done_d, done_q;
   logic        pass_d, pass_q;
   logic [15:0] err_d, err_q;
   logic [31:0] first_d, first_q;

   logic        lfsr_load;
   logic        lfsr_step;
   logic [31:0] lfsr_seed;
   logic [31:0] lfsr_val;

   logic [15:0] wsize_sat;
   logic [31:0] base_aligned;
   logic        last_word;
   logic        rd_done;
   logic        rd_bad;
   logic [1:0]  base_lsb_unused;

`ifdef MEMTEST_TIMEOUT_EN
   logic [7:0]  tmo_d, tmo_q;
`else
   logic [7:0]  tmo_cfg_unused;
   assign tmo_cfg_unused = 8'(TIMEOUT_CYCLES);
`endif

   assign base_lsb_unused = base_addr_bi[1:0];
   assign base_aligned    = {base_addr_bi[31:2], 2'b00};
   assign wsize_sat       = (wsize_bi > 16'(WSIZE_MAX)) ? 16'(WSIZE_MAX) : wsize_bi;
   assign last_word       = (idx_q == (size_q - 16'd1));

   memtest_lfsr #(
      .POLY (LFSR_POLY)
   ) u_lfsr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (lfsr_load),
      .seed_bi (lfsr_seed),
      .step_i  (lfsr_step),
      .val_bo  (lfsr_val)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      size_d    = size_q;
      base_d    = base_q;
      seed_d    = seed_q;
      addr_d    = addr_q;
      req_d     = req_q;
      we_d      = we_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      err_d     = err_q;
      first_d   = first_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      lfsr_seed = seed_q;
      rd_done   = 1'b0;
      rd_bad    = 1'b0;
`ifdef MEMTEST_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_d    = base_aligned;
               size_d    = wsize_sat;
               seed_d    = seed_bi;
               lfsr_load = 1'b1;
               lfsr_seed = seed_bi;
               idx_d     = 16'd0;
               err_d     = 16'd0;
               first_d   = 32'h0;
               pass_d    = 1'b0;
               if (wsize_sat == 16'd0) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d = ST_WR;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = base_aligned;
               end
            end
         end

         ST_WR: begin
            if (bus_ack_i) begin
               if (last_word) begin
                  lfsr_load = 1'b1;
                  idx_d     = 16'd0;
                  addr_d    = base_q;
                  we_d      = 1'b0;
                  state_d   = ST_RD_REQ;
               end else begin
                  lfsr_step = 1'b1;
                  idx_d     = idx_q + 16'd1;
                  addr_d    = addr_q + 32'd4;
               end
            end
         end

         ST_RD_REQ: begin
            if (bus_ack_i) begin
               req_d   = 1'b0;
               state_d = ST_RD_WAIT;
`ifdef MEMTEST_TIMEOUT_EN
               tmo_d   = 8'(TIMEOUT_CYCLES - 1);
`endif
            end
         end

         ST_RD_WAIT: begin
            rd_done = bus_resp_i;
            rd_bad  = bus_resp_i && (bus_rdata_bi != lfsr_val);
`ifdef MEMTEST_TIMEOUT_EN
            // A missing response is scored as a bad word and the test moves on.
            if (!bus_resp_i) begin
               if (tmo_q == 8'd0) begin
                  rd_done = 1'b1;
                  rd_bad  = 1'b1;
               end else begin
                  tmo_d = tmo_q - 8'd1;
               end
            end
`endif
            if (rd_done) begin
               if (rd_bad) begin
                  if (err_q != 16'hFFFF) begin
                     err_d = err_q + 16'd1;
                  end
                  if (err_q == 16'd0) begin
                     first_d = addr_q;
                  end
               end
               lfsr_step = 1'b1;
               if (last_word) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 16'd0);
               end else begin
                  idx_d   = idx_q + 16'd1;
                  addr_d  = addr_q + 32'd4;
                  req_d   = 1'b1;
                  state_d = ST_RD_REQ;
               end
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= 16'd0;
         size_q  <= 16'd0;
         base_q  <= 32'h0;
         seed_q  <= 32'h0;
         addr_q  <= 32'h0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 16'd0;
         first_q <= 32'h0;
`ifdef MEMTEST_TIMEOUT_EN
         tmo_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         size_q  <= size_d;
         base_q  <= base_d;
         seed_q  <= seed_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         first_q <= first_d;
`ifdef MEMTEST_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign pass_o            = pass_q;
   assign err_cnt_bo        = err_q;
   assign first_err_addr_bo = first_q;
   assign bus_req_o         = req_q;
   assign bus_we_o          = we_q;
   assign bus_addr_bo       = addr_q;
   assign bus_wdata_bo      = lfsr_val;
   assign bus_be_bo         = 4'hF;

endmodule
